// File: rtl/cache_pkg.sv
// Shared cache/memory definitions: block geometry, block address layout and the
// main memory controller state encoding.
package cache_pkg;

  localparam int unsigned BLOCK_SIZE = 128;
  localparam int unsigned TAG_W      = 24;
  localparam int unsigned INDEX_W    = 6;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned BLK_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } mem_state_e;

  // True when any block address bit at or above idx_w is set.
  function automatic logic addr_out_of_range(input logic [BLK_ADDR_W-1:0] addr,
                                             input int unsigned           idx_w);
    return (addr >> idx_w) != '0;
  endfunction

endpackage

// File: rtl/main_memory_if.sv
// Cache controller <-> main memory request/ack bus. mem_err exists only when
// MEM_ADDR_CHECK_EN is defined.
interface main_memory_if;
  import cache_pkg::*;

  logic                  mem_req;
  logic                  mem_wr;
  logic [BLK_ADDR_W-1:0] mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic [BLOCK_SIZE-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  mem_busy;
`ifdef MEM_ADDR_CHECK_EN
  logic                  mem_err;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_busy, mem_err
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_busy, mem_err
  );
`else
  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_busy
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_busy
  );
`endif

endinterface

// File: rtl/main_memory_array.sv
// Block storage for main_memory: synchronous write, registered read port.
// Contents are never reset; only the read register is.
module main_memory_array
  import cache_pkg::*;
#(
  parameter int unsigned Depth = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic                       re_i,
  input  logic                       clr_i,
  input  logic [$clog2(Depth)-1:0]   idx_i,
  input  logic [BLOCK_SIZE-1:0]      wdata_i,
  output logic [BLOCK_SIZE-1:0]      rdata_o
);

  logic [BLOCK_SIZE-1:0] mem_q [Depth];
  logic [BLOCK_SIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // clr_i substitutes zero for a rejected read while still updating the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= clr_i ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Fixed-latency main memory behind the cache: IDLE/WAIT/ACK controller plus block array.
// Define MEM_ADDR_CHECK_EN to flag and suppress accesses beyond MEM_DEPTH via mem_err.
module main_memory
  import cache_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned MEM_LATENCY = 4
) (
  input logic          clk,
  input logic          rst,
  main_memory_if.slave bus
);

  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);
  localparam logic [7:0]  LatLoad = 8'(MEM_LATENCY - 1);

  mem_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  wr_q;
  logic [BLK_ADDR_W-1:0] addr_q;
  logic [BLOCK_SIZE-1:0] wdata_q;

  logic                  accept;
  logic                  enter_ack;
  logic                  acc_wr;
  logic [BLK_ADDR_W-1:0] acc_addr;
  logic [BLOCK_SIZE-1:0] acc_wdata;
  logic                  arr_we;
  logic                  arr_re;
  logic                  arr_clr;
  logic [BLOCK_SIZE-1:0] arr_rdata;

  assign accept = (state_q == StIdle) && bus.mem_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mem_req) begin
          cnt_d = LatLoad;
          if (MEM_LATENCY == 1) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Leaving on count 1 puts the ack exactly MEM_LATENCY cycles after acceptance.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d   = StAck;
          enter_ack = 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.mem_wr;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end
    end
  end

  // With MEM_LATENCY == 1 the array access happens on the accept edge itself,
  // so the live bus values stand in for the not-yet-captured ones.
  assign acc_wr    = (state_q == StIdle) ? bus.mem_wr    : wr_q;
  assign acc_addr  = (state_q == StIdle) ? bus.mem_addr  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? bus.mem_wdata : wdata_q;

`ifdef MEM_ADDR_CHECK_EN
  logic acc_oor;

  assign acc_oor     = addr_out_of_range(acc_addr, IdxW);
  assign arr_we      = enter_ack && acc_wr && !acc_oor;
  assign arr_re      = enter_ack && !acc_wr;
  assign arr_clr     = acc_oor;
  assign bus.mem_err = (state_q == StAck) && addr_out_of_range(addr_q, IdxW);
`else
  logic unused_addr_hi;

  // Upper address bits simply alias onto the array.
  assign unused_addr_hi = ^acc_addr[BLK_ADDR_W-1:IdxW];
  assign arr_we         = enter_ack && acc_wr;
  assign arr_re         = enter_ack && !acc_wr;
  assign arr_clr        = 1'b0;
`endif

  main_memory_array #(
    .Depth (MEM_DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .clr_i   (arr_clr),
    .idx_i   (acc_addr[IdxW-1:0]),
    .wdata_i (acc_wdata),
    .rdata_o (arr_rdata)
  );

  assign bus.mem_rdata = arr_rdata;
  assign bus.mem_ack   = (state_q == StAck);
  assign bus.mem_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed scenarios plus randomized traffic
// checked against an associative-array model of the block store.
module tb_main_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 4;

  logic clk = 1'b0;
  logic rst;

  main_memory_if bus ();

  main_memory #(
    .MEM_DEPTH   (DEPTH),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] ref_mem [int];
  logic [127:0] ref_rdata;

  function automatic int ref_idx(input logic [29:0] a);
    return int'(a) % int'(DEPTH);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [29:0] rand_addr(input int idx);
`ifdef MEM_ADDR_CHECK_EN
    return 30'(idx);
`else
    return (30'($urandom) << 8) | 30'(idx);
`endif
  endfunction

  // Issue one request from an idle bus and observe its ack; no comparisons here.
  task automatic issue(input logic wr, input logic [29:0] addr, input logic [127:0] wdata,
                       output int lat, output logic [127:0] rdata, output logic err,
                       output logic busy_after, output logic [127:0] rdata_after);
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_wr    = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    @(posedge clk);
    #1;
    bus.mem_req   = 1'b0;
    bus.mem_wr    = ~wr;
    bus.mem_addr  = 30'($urandom);
    bus.mem_wdata = rand128();
    lat   = -1;
    rdata = '0;
    err   = 1'b0;
    for (int c = 1; c <= int'(LAT) + 20; c++) begin
      if (bus.mem_ack === 1'b1) begin
        lat   = c;
        rdata = bus.mem_rdata;
`ifdef MEM_ADDR_CHECK_EN
        err   = bus.mem_err;
`endif
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    busy_after  = bus.mem_busy | bus.mem_ack;
    rdata_after = bus.mem_rdata;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.mem_req   = 1'b1;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 30'h5;
    bus.mem_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.mem_ack !== 1'b0 || bus.mem_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl: ack=%b busy=%b, required ack=0 busy=0", bus.mem_ack,
                 bus.mem_busy);
      end
      checks++;
      if (bus.mem_rdata !== 128'h0) begin
        errors++;
        $display("FAIL reset_rdata: got %h, required 0", bus.mem_rdata);
      end
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b, required 0", bus.mem_busy);
    end
    ref_rdata = '0;
  endtask

  task automatic test_write_read();
    logic [127:0] d;
    int lat;
    logic [127:0] r, ra;
    logic e, b;
    d = 128'hCAFEBABE_F0F0AAAA_1C78F0F0_F0F0F0F0;
    issue(1'b1, 30'h5, d, lat, r, e, b, ra);
    checks++;
    if (lat != int'(LAT)) begin
      errors++;
      $display("FAIL wr_latency: got %0d cycles, required %0d", lat, LAT);
    end
    checks++;
    if (r !== ref_rdata) begin
      errors++;
      $display("FAIL wr_rdata_hold: got %h, required %h", r, ref_rdata);
    end
    ref_mem[ref_idx(30'h5)] = d;
    issue(1'b0, 30'h5, '0, lat, r, e, b, ra);
    checks++;
    if (lat != int'(LAT)) begin
      errors++;
      $display("FAIL rd_latency: got %0d cycles, required %0d", lat, LAT);
    end
    checks++;
    if (r !== d || ra !== d) begin
      errors++;
      $display("FAIL rd_data: got %h (after %h), required %h", r, ra, d);
    end
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle_after: busy|ack=%b, required 0", b);
    end
    ref_rdata = d;
  endtask

  task automatic test_busy_ignore();
    logic [127:0] d;
    int acks, first, lat;
    logic [127:0] r, ra, r_ack;
    logic e, b;
    d     = rand128();
    acks  = 0;
    first = -1;
    r_ack = '0;
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 30'h9;
    bus.mem_wdata = d;
    @(posedge clk);
    #1;
    ref_mem[ref_idx(30'h9)] = d;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = rand128();
    for (int c = 1; c <= 12; c++) begin
      if (bus.mem_ack === 1'b1) begin
        acks++;
        if (first < 0) begin
          first = c;
          r_ack = bus.mem_rdata;
        end
      end
      @(negedge clk);
      if (acks > 0) bus.mem_req = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.mem_req = 1'b0;
    checks++;
    if (acks != 1 || first != int'(LAT)) begin
      errors++;
      $display("FAIL busy_ignore_acks: got %0d acks first at %0d, required 1 at %0d", acks,
               first, LAT);
    end
    checks++;
    if (r_ack !== ref_rdata) begin
      errors++;
      $display("FAIL busy_ignore_wr_rdata: got %h, required %h", r_ack, ref_rdata);
    end
    checks++;
    if (bus.mem_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_idle: busy=%b, required 0", bus.mem_busy);
    end
    issue(1'b0, 30'h9, '0, lat, r, e, b, ra);
    checks++;
    if (lat != int'(LAT) || r !== d) begin
      errors++;
      $display("FAIL busy_ignore_reread: lat %0d data %h, required lat %0d data %h", lat, r,
               LAT, d);
    end
    ref_rdata = d;
  endtask

  task automatic test_reset_mid_write();
    int lat, acks;
    logic [127:0] r, ra;
    logic e, b;
    issue(1'b1, 30'h7, 128'h0, lat, r, e, b, ra);
    ref_mem[ref_idx(30'h7)] = 128'h0;
    @(negedge clk);
    bus.mem_req   = 1'b1;
    bus.mem_wr    = 1'b1;
    bus.mem_addr  = 30'h7;
    bus.mem_wdata = 128'h1;
    @(posedge clk);
    #1;
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.mem_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_inflight_busy: got %b, required 1", bus.mem_busy);
    end
    acks = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    if (bus.mem_ack === 1'b1) acks++;
    checks++;
    if (bus.mem_busy !== 1'b0 || bus.mem_rdata !== 128'h0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b rdata=%h, required busy=0 rdata=0", bus.mem_busy,
               bus.mem_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL midrst_no_ack: got %0d acks, required 0", acks);
    end
    ref_rdata = '0;
    issue(1'b0, 30'h7, '0, lat, r, e, b, ra);
    checks++;
    if (lat != int'(LAT) || r !== ref_mem[ref_idx(30'h7)]) begin
      errors++;
      $display("FAIL midrst_reread: lat %0d data %h, required lat %0d data %h", lat, r, LAT,
               ref_mem[ref_idx(30'h7)]);
    end
    ref_rdata = r;
  endtask

  task automatic test_alias();
    int lat;
    logic [127:0] r, ra;
    logic e, b;
`ifdef MEM_ADDR_CHECK_EN
    logic [127:0] d0;
    d0 = rand128();
    issue(1'b1, 30'h0, d0, lat, r, e, b, ra);
    ref_mem[0] = d0;
    issue(1'b1, 30'h100, 128'hFF, lat, r, e, b, ra);
    checks++;
    if (e !== 1'b1 || lat != int'(LAT)) begin
      errors++;
      $display("FAIL oor_write_err: err=%b lat=%0d, required err=1 lat=%0d", e, lat, LAT);
    end
    issue(1'b0, 30'h0, '0, lat, r, e, b, ra);
    checks++;
    if (r !== d0 || e !== 1'b0) begin
      errors++;
      $display("FAIL oor_no_commit: data %h err %b, required %h err 0", r, e, d0);
    end
    issue(1'b0, 30'h100, '0, lat, r, e, b, ra);
    checks++;
    if (r !== 128'h0 || e !== 1'b1) begin
      errors++;
      $display("FAIL oor_read_zero: data %h err %b, required 0 err 1", r, e);
    end
    ref_rdata = '0;
`else
    issue(1'b1, 30'h100, 128'hFF, lat, r, e, b, ra);
    ref_mem[ref_idx(30'h100)] = 128'hFF;
    issue(1'b0, 30'h0, '0, lat, r, e, b, ra);
    checks++;
    if (r !== ref_mem[ref_idx(30'h0)]) begin
      errors++;
      $display("FAIL alias_read: got %h, required %h", r, ref_mem[ref_idx(30'h0)]);
    end
    ref_rdata = ref_mem[ref_idx(30'h0)];
`endif
  endtask

  task automatic test_back_to_back();
    logic [127:0] d1, d2;
    int lat;
    logic [127:0] r, ra;
    logic e, b;
    int t[$];
    logic [127:0] rq[$];
    d1 = rand128();
    d2 = rand128();
    issue(1'b1, 30'h1, d1, lat, r, e, b, ra);
    issue(1'b1, 30'h2, d2, lat, r, e, b, ra);
    ref_mem[ref_idx(30'h1)] = d1;
    ref_mem[ref_idx(30'h2)] = d2;
    @(negedge clk);
    bus.mem_req  = 1'b1;
    bus.mem_wr   = 1'b0;
    bus.mem_addr = 30'h1;
    @(posedge clk);
    #1;
    bus.mem_addr = 30'h2;
    for (int c = 1; c <= 20; c++) begin
      if (bus.mem_ack === 1'b1) begin
        t.push_back(c);
        rq.push_back(bus.mem_rdata);
      end
      @(negedge clk);
      if (t.size() >= 2) bus.mem_req = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.mem_req = 1'b0;
    checks++;
    if (t.size() != 2) begin
      errors++;
      $display("FAIL b2b_ack_count: got %0d acks, required 2", t.size());
    end
    if (t.size() >= 2) begin
      checks++;
      if (t[0] != int'(LAT) || t[1] - t[0] != int'(LAT) + 1) begin
        errors++;
        $display("FAIL b2b_spacing: acks at %0d and %0d, required %0d and %0d", t[0], t[1],
                 LAT, 2 * LAT + 1);
      end
      checks++;
      if (rq[0] !== d1 || rq[1] !== d2) begin
        errors++;
        $display("FAIL b2b_data: got %h / %h, required %h / %h", rq[0], rq[1], d1, d2);
      end
    end
    ref_rdata = d2;
  endtask

  task automatic test_random();
    int pool[$];
    foreach (ref_mem[k]) pool.push_back(k);
    for (int i = 0; i < 24; i++) begin
      logic wr;
      int idx, lat;
      logic [29:0] a;
      logic [127:0] d, exp, r, ra;
      logic e, b;
      wr = (pool.size() == 0) || ($urandom_range(0, 1) == 1);
      if (wr) idx = int'($urandom_range(0, DEPTH - 1));
      else idx = pool[$urandom_range(0, pool.size() - 1)];
      a   = rand_addr(idx);
      d   = rand128();
      exp = wr ? ref_rdata : ref_mem[ref_idx(a)];
      issue(wr, a, d, lat, r, e, b, ra);
      checks++;
      if (lat != int'(LAT)) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d, required %0d", i, lat, LAT);
      end
      checks++;
      if (r !== exp || ra !== exp) begin
        errors++;
        $display("FAIL rand_rdata[%0d] wr=%b addr=%h: got %h (after %h), required %h", i, wr,
                 a, r, ra, exp);
      end
      checks++;
      if (b !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle_after[%0d]: busy|ack=%b, required 0", i, b);
      end
      if (wr) begin
        ref_mem[ref_idx(a)] = d;
        pool.push_back(ref_idx(a));
      end else begin
        ref_rdata = exp;
      end
    end
  endtask

  initial begin
    bus.mem_req   = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    rst           = 1'b1;
    ref_rdata     = '0;
    test_reset();
    test_write_read();
    test_busy_ignore();
    test_reset_mid_write();
    test_alias();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
